imem_dmem_wb_arbiter: RTL and testbench
=======================================

Name: imem_dmem_wb_arbiter

Overview:
- Shares one Wishbone-classic memory port between the core's instruction-fetch requester and data-access requester.
- Used when the second memory is disabled and a single memory must serve both the imem and dmem req/gnt interfaces.
- Round-robin arbitration between the two requesters; one transaction outstanding at a time; registered bus outputs.
- Sits between the core wrapper's req/gnt signals and the Controller's core_* Wishbone slave port.

Parameters:
- ADDR_WIDTH, 32, address width of both requesters and the bus.
- DATA_WIDTH, 32, data width; the sel width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 255, bus cycles to wait for ack before aborting; used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- imem_req_i  in  1  instruction request; held high until imem_gnt_o.
- imem_addr_i  in  ADDR_WIDTH  fetch address; stable while the request is pending.
- imem_gnt_o  out  1  one-cycle completion pulse.
- imem_rdata_o  out  DATA_WIDTH  fetched word; valid while imem_gnt_o is high.
- imem_err_o  out  1  bus error/timeout; pulses together with imem_gnt_o.
- dmem_req_i  in  1  data request; held high until dmem_gnt_o.
- dmem_we_i  in  1  1 = write.
- dmem_ben_i  in  DATA_WIDTH/8  byte enables.
- dmem_addr_i  in  ADDR_WIDTH  data address.
- dmem_wdata_i  in  DATA_WIDTH  write data.
- dmem_gnt_o  out  1  one-cycle completion pulse.
- dmem_rdata_o  out  DATA_WIDTH  read data; valid while dmem_gnt_o is high.
- dmem_err_o  out  1  bus error/timeout; pulses together with dmem_gnt_o.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone master controls.
- wb_sel_o  out  DATA_WIDTH/8  byte selects.
- wb_addr_o  out  ADDR_WIDTH  bus address.
- wb_data_o  out  DATA_WIDTH  bus write data.
- wb_data_i  in  DATA_WIDTH  bus read data.
- wb_ack_i  in  1  slave acknowledge.

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-low (clk, rst_n).
  - On reset, all outputs are 0 and the FSM goes to IDLE.
  - The last_grant pointer resets to INSTR, so data wins the first tie.
- FSM states: IDLE, BUS_I, BUS_D, RESP.
- IDLE:
  - Only imem_req_i high → BUS_I. Only dmem_req_i high → BUS_D.
  - Both high → grant the requester not equal to last_grant, then update last_grant.
- Entering BUS_x (registered, visible the cycle after the decision):
  - wb_cyc_o = wb_stb_o = 1.
  - Address, we, sel and data are loaded from the granted requester.
  - Instruction path: we = 0, sel = all ones, data = 0.
- BUS_x, holding: bus outputs stay constant until a cycle with wb_ack_i = 1.
- BUS_x, on ack at cycle N:
  - At N+1: cyc/stb/we drop to 0, wb_data_i is captured into x_rdata_o, x_gnt_o = 1, state = RESP.
  - On writes, x_rdata_o still carries the captured wb_data_i value.
- RESP:
  - Lasts exactly one cycle; the grant pulse is deasserted at exit; then → IDLE.
  - Requests are not sampled in RESP, so the served requester has one cycle to drop or change its request.
- Latency: decision cycle D, bus asserted at D+1; with ack at cycle A, gnt pulses at A+1. Minimum request-to-gnt is 3 cycles for a zero-wait slave.
- Boundary conditions:
  - wb_ack_i in IDLE or RESP is ignored.
  - A request dropped while not granted is simply not served.
  - Inputs change only in IDLE evaluation; later changes do not affect an in-flight transaction.
  - Reset mid-transaction abandons the transaction with no gnt pulse.
- Both gnt outputs are never high in the same cycle, and the two err outputs are mutually exclusive.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An 8..16-bit counter clears on entry to BUS_x and increments each BUS_x cycle without ack.
  - When the count reaches TIMEOUT_CYCLES, the arbiter drops cyc/stb, goes to RESP, and pulses x_gnt_o with x_err_o = 1 and x_rdata_o = 0.
  - An ack arriving in the same cycle as the timeout takes precedence: normal completion, err = 0.
- Not defined: no counter; the arbiter waits indefinitely; both err outputs are tied to 0.

Decomposition:
- Shared package/header arb_defines: state encodings (IDLE=2'd0, BUS_I=2'd1, BUS_D=2'd2, RESP=2'd3) and requester IDs (REQ_INSTR=1'b0, REQ_DATA=1'b1).
- Sub-module arb_timeout_counter (clear, enable, expired output), instantiated only under ARB_TIMEOUT_EN. Everything else stays flat.

Test Plan:
- Reset is released and only imem_req_i is asserted with addr 0x0000_0010; the slave acks 1 cycle after stb with data 0x0000_0013 → wb_addr_o = 0x10, wb_sel_o = 0xF, wb_we_o = 0; imem_gnt_o pulses 1 cycle later with imem_rdata_o = 0x13; total 3 cycles.
- Both requesters are asserted in the first cycle after reset → the data request is served first; the instruction request is served next after RESP.
- Both requests are held continuously for 4 transactions → grants alternate D, I, D, I; gnt outputs are never simultaneous.
- A dmem write with addr 0x100, wdata 0xDEADBEEF and ben 0x3 is issued against a 5-cycle wait slave → bus outputs are stable for all 5 cycles and wb_sel_o = 0x3; dmem_gnt_o arrives 1 cycle after ack.
- rst_n is asserted low mid-BUS_D → all wb_* outputs go to 0 immediately with no gnt; after release, a new request completes normally.
- With ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES = 8 and no ack → cyc drops after 8 bus cycles; imem_gnt_o = 1 and imem_err_o = 1 for one cycle. Without the macro, the bus is still asserted after 1000 cycles.

Source files
------------

// File: rtl/arb_defines.sv
// Shared encodings for the imem/dmem Wishbone arbiter: FSM states and requester IDs.
package arb_defines;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUS_I = 2'd1,
        BUS_D = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    localparam logic REQ_INSTR = 1'b0;
    localparam logic REQ_DATA  = 1'b1;

endpackage

// File: rtl/arb_timeout_counter.sv
// Bus-cycle watchdog for the arbiter; only instantiated when ARB_TIMEOUT_EN is defined.
module arb_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_cnt <= '0;
        else if (i_clr)  r_cnt <= '0;
        else if (i_en)   r_cnt <= r_cnt + CNT_W'(1);
    end

    // Fires in the last waiting cycle so the bus is held exactly TIMEOUT_CYCLES cycles.
    assign o_expired = i_en && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/imem_dmem_wb_arbiter.sv
// Round-robin arbiter sharing one Wishbone-classic port between imem and dmem requesters.
// Optional ack watchdog enabled by defining ARB_TIMEOUT_EN.
module imem_dmem_wb_arbiter
    import arb_defines::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    imem_req_i,
    input  logic [ADDR_WIDTH-1:0]   imem_addr_i,
    output logic                    imem_gnt_o,
    output logic [DATA_WIDTH-1:0]   imem_rdata_o,
    output logic                    imem_err_o,
    input  logic                    dmem_req_i,
    input  logic                    dmem_we_i,
    input  logic [DATA_WIDTH/8-1:0] dmem_ben_i,
    input  logic [ADDR_WIDTH-1:0]   dmem_addr_i,
    input  logic [DATA_WIDTH-1:0]   dmem_wdata_i,
    output logic                    dmem_gnt_o,
    output logic [DATA_WIDTH-1:0]   dmem_rdata_o,
    output logic                    dmem_err_o,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    output logic [ADDR_WIDTH-1:0]   wb_addr_o,
    output logic [DATA_WIDTH-1:0]   wb_data_o,
    input  logic [DATA_WIDTH-1:0]   wb_data_i,
    input  logic                    wb_ack_i
);

    localparam int SEL_W = DATA_WIDTH / 8;

    arb_state_e            r_state;
    logic                  r_last_grant;
    logic                  r_cyc, r_stb, r_we;
    logic [SEL_W-1:0]      r_sel;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_imem_gnt, r_dmem_gnt, r_imem_err, r_dmem_err;
    logic [DATA_WIDTH-1:0] r_imem_rdata, r_dmem_rdata;

    logic w_in_bus, w_pick_data, w_timeout;

    assign w_in_bus = (r_state == BUS_I) || (r_state == BUS_D);
    // Data wins when alone, or on a tie when instruction was granted last.
    assign w_pick_data = dmem_req_i && (!imem_req_i || (r_last_grant == REQ_INSTR));

`ifdef ARB_TIMEOUT_EN
    logic w_cnt_clr, w_cnt_en;
    assign w_cnt_clr = !w_in_bus;
    assign w_cnt_en  = w_in_bus && !wb_ack_i;

    arb_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_cnt_clr),
        .i_en      (w_cnt_en),
        .o_expired (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_last_grant <= REQ_INSTR;
            r_cyc        <= 1'b0;
            r_stb        <= 1'b0;
            r_we         <= 1'b0;
            r_sel        <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_imem_gnt   <= 1'b0;
            r_dmem_gnt   <= 1'b0;
            r_imem_err   <= 1'b0;
            r_dmem_err   <= 1'b0;
            r_imem_rdata <= '0;
            r_dmem_rdata <= '0;
        end else begin
            r_imem_gnt <= 1'b0;
            r_dmem_gnt <= 1'b0;
            r_imem_err <= 1'b0;
            r_dmem_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (imem_req_i || dmem_req_i) begin
                        r_cyc <= 1'b1;
                        r_stb <= 1'b1;
                        if (w_pick_data) begin
                            r_state      <= BUS_D;
                            r_last_grant <= REQ_DATA;
                            r_we         <= dmem_we_i;
                            r_sel        <= dmem_ben_i;
                            r_addr       <= dmem_addr_i;
                            r_wdata      <= dmem_wdata_i;
                        end else begin
                            r_state      <= BUS_I;
                            r_last_grant <= REQ_INSTR;
                            r_we         <= 1'b0;
                            r_sel        <= '1;
                            r_addr       <= imem_addr_i;
                            r_wdata      <= '0;
                        end
                    end
                end
                BUS_I, BUS_D: begin
                    // Ack beats a simultaneous timeout; err only when the watchdog ends the cycle.
                    if (wb_ack_i || w_timeout) begin
                        r_state <= RESP;
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_we    <= 1'b0;
                        if (r_state == BUS_I) begin
                            r_imem_gnt   <= 1'b1;
                            r_imem_err   <= !wb_ack_i;
                            r_imem_rdata <= wb_ack_i ? wb_data_i : '0;
                        end else begin
                            r_dmem_gnt   <= 1'b1;
                            r_dmem_err   <= !wb_ack_i;
                            r_dmem_rdata <= wb_ack_i ? wb_data_i : '0;
                        end
                    end
                end
                RESP: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign wb_cyc_o     = r_cyc;
    assign wb_stb_o     = r_stb;
    assign wb_we_o      = r_we;
    assign wb_sel_o     = r_sel;
    assign wb_addr_o    = r_addr;
    assign wb_data_o    = r_wdata;
    assign imem_gnt_o   = r_imem_gnt;
    assign dmem_gnt_o   = r_dmem_gnt;
    assign imem_err_o   = r_imem_err;
    assign dmem_err_o   = r_dmem_err;
    assign imem_rdata_o = r_imem_rdata;
    assign dmem_rdata_o = r_dmem_rdata;

endmodule

// File: tb/tb_imem_dmem_wb_arbiter.sv
// Scoreboard bench for imem_dmem_wb_arbiter; covers both ARB_TIMEOUT_EN builds.
module tb_imem_dmem_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_i = 1'b0;
    logic [31:0] imem_addr_i = '0;
    logic        imem_gnt_o, imem_err_o;
    logic [31:0] imem_rdata_o;
    logic        dmem_req_i = 1'b0, dmem_we_i = 1'b0;
    logic [3:0]  dmem_ben_i = '0;
    logic [31:0] dmem_addr_i = '0, dmem_wdata_i = '0;
    logic        dmem_gnt_o, dmem_err_o;
    logic [31:0] dmem_rdata_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_addr_o, wb_data_o;
    logic [31:0] wb_data_i = '0;
    logic        wb_ack_i = 1'b0;

    imem_dmem_wb_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_i(imem_req_i), .imem_addr_i(imem_addr_i), .imem_gnt_o(imem_gnt_o),
        .imem_rdata_o(imem_rdata_o), .imem_err_o(imem_err_o),
        .dmem_req_i(dmem_req_i), .dmem_we_i(dmem_we_i), .dmem_ben_i(dmem_ben_i),
        .dmem_addr_i(dmem_addr_i), .dmem_wdata_i(dmem_wdata_i), .dmem_gnt_o(dmem_gnt_o),
        .dmem_rdata_o(dmem_rdata_o), .dmem_err_o(dmem_err_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
        .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .wb_data_i(wb_data_i), .wb_ack_i(wb_ack_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_data;
        logic [31:0] addr;
        bit          we;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          err;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0, n_err = 0;
    int   cyc_cnt = 0, last_gnt_cyc = 0, bus_len = 0, last_bus_len = 0;
    int   i_todo = 0, d_todo = 0;
    int   s_wait = 0, s_cnt = 0;
    bit   s_noack = 0, s_stray = 0, prev_bus_ack = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    always @(posedge clk) cyc_cnt++;

    // Monitor/scoreboard first, then the slave model updates its ack for the next edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            wb_ack_i = 1'b0;
            s_cnt = 0;
            prev_bus_ack = 0;
            bus_len = 0;
        end else begin
            if (wb_cyc_o) begin
                bus_len++;
                if (q.size() == 0) chk("bus_unexp", 1, 0);
                else begin
                    chk("bus_stb",   wb_stb_o,  1);
                    chk("bus_addr",  wb_addr_o, q[0].addr);
                    chk("bus_we",    wb_we_o,   q[0].we);
                    chk("bus_sel",   wb_sel_o,  q[0].sel);
                    chk("bus_wdata", wb_data_o, q[0].wdata);
                end
            end else if (wb_stb_o || wb_we_o) chk("bus_idle", {wb_stb_o, wb_we_o}, 0);
            if (imem_gnt_o || dmem_gnt_o) begin
                chk("gnt_excl", imem_gnt_o & dmem_gnt_o, 0);
                chk("err_excl", imem_err_o & dmem_err_o, 0);
                last_gnt_cyc = cyc_cnt;
                last_bus_len = bus_len;
                bus_len = 0;
                if (q.size() == 0) chk("gnt_unexp", 1, 0);
                else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("gnt_port", dmem_gnt_o, e.is_data);
                    chk("gnt_after_ack", prev_bus_ack, !e.err);
                    if (e.is_data) begin
                        chk("d_rdata", dmem_rdata_o, e.rdata);
                        chk("d_err",   dmem_err_o,   e.err);
                    end else begin
                        chk("i_rdata", imem_rdata_o, e.rdata);
                        chk("i_err",   imem_err_o,   e.err);
                    end
                end
                if (imem_gnt_o && i_todo > 0) begin
                    i_todo--;
                    if (i_todo == 0) imem_req_i = 1'b0;
                end
                if (dmem_gnt_o && d_todo > 0) begin
                    d_todo--;
                    if (d_todo == 0) dmem_req_i = 1'b0;
                end
            end
            if (!(wb_cyc_o && wb_stb_o)) begin
                wb_ack_i = s_stray;
                s_cnt = 0;
            end else if (!s_noack && s_cnt == s_wait) begin
                wb_ack_i = 1'b1;
                wb_data_i = wb_addr_o + 32'd3;
            end else begin
                wb_ack_i = 1'b0;
                s_cnt++;
            end
            prev_bus_ack = wb_ack_i && wb_cyc_o;
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic push_i(input logic [31:0] a, input bit err);
        exp_t e;
        e = '{is_data: 0, addr: a, we: 0, sel: 4'hF, wdata: 32'h0,
              rdata: err ? 32'h0 : a + 32'd3, err: err};
        q.push_back(e);
    endtask

    task automatic push_d(input logic [31:0] a, input bit we, input logic [3:0] ben,
                          input logic [31:0] wd);
        exp_t e;
        e = '{is_data: 1, addr: a, we: we, sel: ben, wdata: wd, rdata: a + 32'd3, err: 0};
        q.push_back(e);
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit done;
        done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            step();
            if (q.size() == 0 && !imem_req_i && !dmem_req_i) done = 1;
        end
        chk({"done_", tag}, done, 1);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        imem_req_i = 1'b0; dmem_req_i = 1'b0; i_todo = 0; d_todo = 0;
        q.delete();
        #1;
        chk("rst_cyc", wb_cyc_o, 0);
        chk("rst_stb", wb_stb_o, 0);
        chk("rst_bus", {wb_we_o, wb_sel_o, wb_addr_o, wb_data_o}, 0);
        chk("rst_gnt", {imem_gnt_o, dmem_gnt_o, imem_err_o, dmem_err_o}, 0);
        repeat (2) step();
        chk("rst_rdata", {imem_rdata_o, dmem_rdata_o}, 0);
        chk("rst_gnt_hold", {imem_gnt_o, dmem_gnt_o}, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        int t0;
        rst_n = 1'b0;
        step();
        reset_dut();

        // Tie in the first cycle after reset: data first, then instruction.
        push_d(32'h200, 0, 4'hF, 32'h0);
        push_i(32'h40, 0);
        dmem_addr_i = 32'h200; dmem_we_i = 0; dmem_ben_i = 4'hF; dmem_wdata_i = 0;
        imem_addr_i = 32'h40;
        d_todo = 1; i_todo = 1;
        dmem_req_i = 1; imem_req_i = 1;
        wait_done("tie", 50);

        // Single zero-wait fetch: request-to-gnt spans 3 cycles.
        step();
        push_i(32'h10, 0);
        imem_addr_i = 32'h10; i_todo = 1; imem_req_i = 1;
        t0 = cyc_cnt;
        wait_done("fetch", 50);
        chk("lat_i", last_gnt_cyc - t0, 2);
        chk("rdata_13", imem_rdata_o, 32'h13);

        // Both held for four transactions, stray acks outside bus cycles.
        step();
        s_stray = 1;
        push_d(32'h80, 0, 4'hF, 0); push_i(32'h44, 0);
        push_d(32'h80, 0, 4'hF, 0); push_i(32'h44, 0);
        dmem_addr_i = 32'h80; imem_addr_i = 32'h44;
        d_todo = 2; i_todo = 2;
        dmem_req_i = 1; imem_req_i = 1;
        wait_done("alt", 100);
        s_stray = 0;

        // Write against a 5-wait slave; request inputs scrambled after the decision.
        step();
        s_wait = 5;
        push_d(32'h100, 1, 4'h3, 32'hDEADBEEF);
        dmem_addr_i = 32'h100; dmem_we_i = 1; dmem_ben_i = 4'h3; dmem_wdata_i = 32'hDEADBEEF;
        d_todo = 1; dmem_req_i = 1;
        step(); step();
        dmem_addr_i = 32'h999; dmem_ben_i = 4'hC; dmem_wdata_i = 32'h1234;
        wait_done("wr", 50);
        chk("wr_len", last_bus_len, 6);
        chk("wr_rdata", dmem_rdata_o, 32'h103);

        // Reset in the middle of BUS_D abandons the transaction.
        step();
        s_wait = 20;
        dmem_addr_i = 32'h300; dmem_we_i = 0; dmem_ben_i = 4'hF; dmem_wdata_i = 0;
        push_d(32'h300, 0, 4'hF, 0);
        d_todo = 1; dmem_req_i = 1;
        repeat (4) step();
        chk("mid_cyc", wb_cyc_o, 1);
        reset_dut();
        s_wait = 0;
        step();
        push_d(32'h304, 0, 4'hF, 0);
        dmem_addr_i = 32'h304; d_todo = 1; dmem_req_i = 1;
        wait_done("post_rst", 50);

        // Slave never acks.
        step();
        s_noack = 1;
        imem_addr_i = 32'h500; i_todo = 1; imem_req_i = 1;
`ifdef ARB_TIMEOUT_EN
        push_i(32'h500, 1);
        wait_done("tmo", 60);
        chk("tmo_len", last_bus_len, 8);
        step();
        chk("tmo_gnt_drop", {imem_gnt_o, imem_err_o}, 0);
`else
        push_i(32'h500, 0);
        repeat (1000) step();
        chk("noack_cyc", wb_cyc_o, 1);
        chk("noack_stb", wb_stb_o, 1);
        chk("noack_err", {imem_err_o, dmem_err_o}, 0);
        reset_dut();
`endif
        s_noack = 0;
        step();
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
